rr_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream valid/ready stream among N upstream requesters.
- Typical downstream sink is a skid_buffer, whose registered up_ready feeds out_ready.
- Grant is per packet, delimited by a last flag. Grant is locked while a beat is presented but not accepted, so out_* stays stable under backpressure.
- Single-cycle combinational forward path: no added latency, no storage of data.

---
 rtl/rr_stream_arbiter.sv | 108 ++++++++++
 tb/tb_rr_stream_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one valid/ready stream among N requesters.
// Grant is held per packet (until last) and frozen while a beat is stalled.

module rr_stream_arbiter_lane #(
  parameter int IW = 2,
  parameter int ID = 0
) (
  input  logic          rst,
  input  logic [IW-1:0] sel,
  input  logic          out_ready,
  output logic          ready
);
  assign ready = ~rst & out_ready & (sel == IW'(ID));
endmodule

module rr_stream_arbiter #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*DW-1:0]      in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 locked
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [IW-1:0] ptr, gnt, cand, sel;
  logic [IW:0]   scan;
  logic [DW-1:0] sel_data;
  logic          sel_valid, sel_last, xfer;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    return (x == IW'(N-1)) ? '0 : x + 1'b1;
  endfunction

  // Scan from the far end back toward ptr so the closest valid index wins.
  always_comb begin
    cand = ptr;
    scan = '0;
    for (int k = N-1; k >= 0; k--) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) scan = scan - (IW+1)'(N);
      if (in_valid[scan[IW-1:0]]) cand = scan[IW-1:0];
    end
  end

  assign sel       = (state == LOCK) ? gnt : cand;
  assign sel_data  = in_data[sel*DW +: DW];
  assign sel_valid = in_valid[sel];
  assign sel_last  = in_last[sel];

  assign out_valid = ~rst & sel_valid;
  assign out_last  = ~rst & sel_last;
  assign out_data  = rst ? '0 : sel_data;
  assign grant_idx = rst ? '0 : sel;
  assign locked    = ~rst & (state == LOCK);
  assign xfer      = out_valid & out_ready;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      rr_stream_arbiter_lane #(.IW(IW), .ID(i)) u_lane (
        .rst       (rst),
        .sel       (sel),
        .out_ready (out_ready),
        .ready     (in_ready[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && out_last) begin
            ptr <= wrap_inc(cand);
          end else if (out_valid) begin
            // Either a multi-beat packet started or the beat stalled: pin it.
            state <= LOCK;
            gnt   <= cand;
          end
        end
        LOCK: begin
          if (xfer && out_last) begin
            state <= IDLE;
            ptr   <= wrap_inc(gnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: cycle tables, an N=3 wrap sequence, and
// randomized packet traffic against a priority/owner reference model.

module tb_rr_stream_arbiter;
  logic        clk = 0;
  logic        rst = 1, rst3 = 1;
  logic [63:0] in_data = '0;
  logic [3:0]  in_valid = '0, in_last = '0, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_last, out_ready = 0, locked;
  logic [1:0]  grant_idx;

  logic [47:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0, in_last3 = '0, in_ready3;
  logic [15:0] out_data3;
  logic        out_valid3, out_last3, out_ready3 = 0, locked3;
  logic [1:0]  grant_idx3;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rr_stream_arbiter #(.N(4), .DW(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_idx(grant_idx), .locked(locked));

  rr_stream_arbiter #(.N(3), .DW(16)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
    .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_last(out_last3), .out_ready(out_ready3),
    .grant_idx(grant_idx3), .locked(locked3));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       r;
    logic [3:0] v, l;
    logic       rdy;
    int         g;
    logic       ov;
    logic [3:0] ir;
    logic       lk;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] v, logic [3:0] l, logic rdy,
                              int g, logic ov, logic [3:0] ir, logic lk);
    vec_t t;
    t.r = r; t.v = v; t.l = l; t.rdy = rdy; t.g = g; t.ov = ov; t.ir = ir; t.lk = lk;
    vecs.push_back(t);
  endfunction

  task automatic step3(input logic [2:0] v, input logic [2:0] l, input int g,
                       input logic ov, input logic lk, input string nm);
    logic [2:0] eir;
    @(posedge clk); #1;
    rst3 = 0; in_valid3 = v; in_last3 = l; out_ready3 = 1;
    in_data3 = {16'($urandom), 16'($urandom), 16'($urandom)};
    @(negedge clk);
    eir = 3'(1 << g);
    check({nm, " grant"}, 32'(grant_idx3), 32'(g));
    check({nm, " valid"}, 32'(out_valid3), 32'(ov));
    check({nm, " locked"}, 32'(locked3), 32'(lk));
    check({nm, " in_ready"}, 32'(in_ready3), 32'(eir));
  endtask

  // Random traffic state: per-port packet generator and arbiter model
  int         rem [4];
  logic       pend[4];
  logic [15:0] dat[4];
  int         owner, prio, es;
  logic       ev, elast;
  logic [3:0] eir;

  initial begin
    // Cycle tables: {rst, valid, last, out_ready} -> {grant, out_valid, in_ready, locked}
    add(1, 4'b1111, 4'b1111, 1, 0, 0, 4'b0000, 0);
    add(0, 4'b0100, 4'b0000, 1, 2, 1, 4'b0100, 0);  // port 2: A
    add(0, 4'b0100, 4'b0000, 1, 2, 1, 4'b0100, 1);  // B
    add(0, 4'b0100, 4'b0100, 1, 2, 1, 4'b0100, 1);  // C last -> ptr 3
    add(0, 4'b1111, 4'b1111, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1111, 4'b1111, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, 1, 2, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, 1, 3, 1, 4'b1000, 0);
    add(0, 4'b1111, 4'b1111, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b0000, 4'b0000, 1, 2, 0, 4'b0100, 0);  // idle: candidate is ptr
    add(1, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 1, 0, 1, 4'b0001, 0);  // port 0, 4 beats
    add(0, 4'b0011, 4'b0000, 1, 0, 1, 4'b0001, 1);
    add(0, 4'b0010, 4'b0000, 1, 0, 0, 4'b0001, 1);  // gap inside packet
    add(0, 4'b0011, 4'b0000, 1, 0, 1, 4'b0001, 1);
    add(0, 4'b0011, 4'b0001, 1, 0, 1, 4'b0001, 1);
    add(0, 4'b0010, 4'b0010, 1, 1, 1, 4'b0010, 0);
    add(0, 4'b1000, 4'b1000, 0, 3, 1, 4'b0000, 0);  // backpressure on port 3
    add(0, 4'b1000, 4'b1000, 0, 3, 1, 4'b0000, 1);
    add(0, 4'b1001, 4'b1001, 0, 3, 1, 4'b0000, 1);
    add(0, 4'b1001, 4'b1001, 0, 3, 1, 4'b0000, 1);
    add(0, 4'b1001, 4'b1001, 0, 3, 1, 4'b0000, 1);
    add(0, 4'b1001, 4'b1001, 1, 3, 1, 4'b1000, 1);
    add(0, 4'b0001, 4'b0001, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 0);  // lock on port 1
    add(0, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 1);
    add(1, 4'b0011, 4'b0000, 1, 0, 0, 4'b0000, 0);  // reset mid-packet
    add(0, 4'b0011, 4'b0011, 1, 0, 1, 4'b0001, 0);
    add(0, 4'b0010, 4'b0010, 1, 1, 1, 4'b0010, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[n]) begin
      @(posedge clk); #1;
      rst = vecs[n].r; in_valid = vecs[n].v; in_last = vecs[n].l;
      out_ready = vecs[n].rdy; in_data = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("vec%0d grant", n), 32'(grant_idx), 32'(vecs[n].g));
      check($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(vecs[n].ov));
      check($sformatf("vec%0d in_ready", n), 32'(in_ready), 32'(vecs[n].ir));
      check($sformatf("vec%0d locked", n), 32'(locked), 32'(vecs[n].lk));
      check($sformatf("vec%0d out_data", n), 32'(out_data),
            vecs[n].r ? 32'd0 : 32'(in_data[vecs[n].g*16 +: 16]));
      check($sformatf("vec%0d out_last", n), 32'(out_last),
            vecs[n].r ? 32'd0 : 32'(in_last[vecs[n].g]));
    end

    // N=3 wrap: ptr must go 2 -> 0, never 3
    step3(3'b010, 3'b010, 1, 1, 0, "w3a");
    step3(3'b101, 3'b101, 2, 1, 0, "w3b");
    step3(3'b000, 3'b000, 0, 0, 0, "w3c");
    step3(3'b101, 3'b101, 0, 1, 0, "w3d");
    step3(3'b101, 3'b101, 2, 1, 0, "w3e");
    step3(3'b100, 3'b000, 2, 1, 0, "w3f");
    step3(3'b100, 3'b100, 2, 1, 1, "w3g");
    step3(3'b000, 3'b000, 0, 0, 0, "w3h");

    // Randomized packet traffic on the N=4 instance
    @(posedge clk); #1;
    rst = 1; in_valid = '0; in_last = '0;
    @(posedge clk); #1;
    rst = 0; owner = -1; prio = 0;
    for (int i = 0; i < 4; i++) begin rem[i] = 0; pend[i] = 0; dat[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if (rem[i] == 0 && $urandom_range(2) == 0) rem[i] = $urandom_range(4, 1);
          if (rem[i] > 0 && $urandom_range(3) != 0) begin
            pend[i] = 1; dat[i] = 16'($urandom);
          end
        end
        in_valid[i] = pend[i];
        in_last[i]  = pend[i] && rem[i] == 1;
        in_data[i*16 +: 16] = dat[i];
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (owner >= 0) es = owner;
      else begin
        es = prio;
        for (int k = 0; k < 4; k++)
          if (in_valid[(prio + k) % 4]) begin es = (prio + k) % 4; break; end
      end
      ev    = in_valid[es];
      elast = ev && rem[es] == 1;
      eir   = out_ready ? 4'(1 << es) : 4'b0;
      check($sformatf("rnd%0d grant", cyc), 32'(grant_idx), 32'(es));
      check($sformatf("rnd%0d out_valid", cyc), 32'(out_valid), 32'(ev));
      check($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(eir));
      check($sformatf("rnd%0d locked", cyc), 32'(locked), 32'(owner >= 0));
      if (ev) begin
        check($sformatf("rnd%0d out_data", cyc), 32'(out_data), 32'(dat[es]));
        check($sformatf("rnd%0d out_last", cyc), 32'(out_last), 32'(elast));
      end
      if (ev && out_ready) begin
        pend[es] = 0;
        rem[es]--;
        if (elast) begin owner = -1; prio = (es + 1) % 4; end
        else owner = es;
      end else if (ev) begin
        owner = es;
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
